// File: rtl/crossbar_in_elastic.sv
// crossbar_in_elastic: registered NUM_IN x NUM_OUT valid/ready crossbar with lazy fork
// and a context memory of select words that switches only once the outputs drain.
`default_nettype none

module crossbar_in_elastic #(
  parameter int DATA_W    = 32,
  parameter int NUM_IN    = 9,
  parameter int NUM_OUT   = 3,
  parameter int SEL_W     = 4,
  parameter int CFG_DEPTH = 4,
  localparam int CW       = (CFG_DEPTH > 1) ? $clog2(CFG_DEPTH) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_IN*DATA_W-1:0]    in_data_i,
  input  logic [NUM_IN-1:0]           in_valid_i,
  output logic [NUM_IN-1:0]           in_ready_o,
  output logic [NUM_OUT*DATA_W-1:0]   out_data_o,
  output logic [NUM_OUT-1:0]          out_valid_o,
  input  logic [NUM_OUT-1:0]          out_ready_i,
  input  logic                        cfg_we_i,
  input  logic [CW-1:0]               cfg_addr_i,
  input  logic [NUM_OUT*SEL_W-1:0]    cfg_data_i,
  input  logic                        ctx_req_i,
  input  logic [CW-1:0]               ctx_id_i,
  output logic [CW-1:0]               ctx_cur_o,
  output logic                        ctx_busy_o
);

  localparam int               CFG_W   = NUM_OUT * SEL_W;
  localparam logic [SEL_W-1:0] SEL_OFF = '1;
  localparam logic [SEL_W-1:0] SEL_RF  = SEL_W'(NUM_IN - 1);

  logic [CFG_W-1:0]          ctx_mem_q [CFG_DEPTH];
  logic [CW-1:0]             ctx_cur_q;
  logic [CW-1:0]             pend_q;
  logic                      busy_q;
  logic [NUM_OUT-1:0]        out_valid_q;
  logic [NUM_OUT*DATA_W-1:0] out_data_q;

  logic [CFG_W-1:0]          sel_word;
  logic [NUM_OUT-1:0]        en;
  logic [NUM_OUT-1:0]        can_load;
  logic [SEL_W-1:0]          src [NUM_OUT];
  logic [NUM_IN-1:0]         routed;
  logic [NUM_IN-1:0]         blocked;
  logic [NUM_IN-1:0]         in_ready;
  logic [NUM_OUT-1:0]        load;
  logic [NUM_OUT*DATA_W-1:0] load_data;

  assign sel_word = ctx_mem_q[ctx_cur_q];
  assign can_load = ~out_valid_q | out_ready_i;

  // Out-of-range selects fall back to the register-file input; all-ones disables.
  always_comb begin
    en = '0;
    for (int o = 0; o < NUM_OUT; o++) begin
      src[o] = sel_word[o*SEL_W +: SEL_W];
      en[o]  = (src[o] != SEL_OFF);
      if (int'(src[o]) >= NUM_IN) src[o] = SEL_RF;
    end
  end

  // A source is ready only when every enabled output it feeds can load this cycle.
  always_comb begin
    routed  = '0;
    blocked = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      for (int o = 0; o < NUM_OUT; o++) begin
        if (en[o] && int'(src[o]) == i) begin
          routed[i] = 1'b1;
          if (!can_load[o]) blocked[i] = 1'b1;
        end
      end
    end
    in_ready = routed & ~blocked & {NUM_IN{~busy_q}};
  end

  always_comb begin
    load      = '0;
    load_data = '0;
    for (int o = 0; o < NUM_OUT; o++) begin
      for (int i = 0; i < NUM_IN; i++) begin
        if (en[o] && int'(src[o]) == i) begin
          load[o]                          = in_valid_i[i] & in_ready[i];
          load_data[o*DATA_W +: DATA_W]    = in_data_i[i*DATA_W +: DATA_W];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int d = 0; d < CFG_DEPTH; d++) ctx_mem_q[d] <= '1;
      ctx_cur_q   <= '0;
      pend_q      <= '0;
      busy_q      <= 1'b0;
      out_valid_q <= '0;
      out_data_q  <= '0;
    end else begin
      if (cfg_we_i) ctx_mem_q[cfg_addr_i] <= cfg_data_i;
      // A new request outranks completion so the latest id is never lost.
      if (ctx_req_i) begin
        pend_q <= ctx_id_i;
        busy_q <= 1'b1;
      end else if (busy_q && out_valid_q == '0) begin
        ctx_cur_q <= pend_q;
        busy_q    <= 1'b0;
      end
      for (int o = 0; o < NUM_OUT; o++) begin
        if (load[o]) begin
          out_valid_q[o]                <= 1'b1;
          out_data_q[o*DATA_W +: DATA_W] <= load_data[o*DATA_W +: DATA_W];
        end else if (out_ready_i[o]) begin
          out_valid_q[o] <= 1'b0;
        end
      end
    end
  end

  assign in_ready_o  = in_ready;
  assign out_data_o  = out_data_q;
  assign out_valid_o = out_valid_q;
  assign ctx_cur_o   = ctx_cur_q;
  assign ctx_busy_o  = busy_q;

endmodule

`default_nettype wire

// File: doc/crossbar_in_elastic.md
Name: crossbar_in_elastic

Overview:
- Parametrised, registered successor to the PE input crossbar.
- Routes NUM_IN source channels (8 neighbours + register file by default) to NUM_OUT sinks (ALU in 1, ALU in 2, register-file write by default).
- Uses a valid/ready handshake with lazy-fork semantics: one output register per sink.
- Select words are held in a CFG_DEPTH-entry context memory; the active context switches only after the outputs drain.

Parameters:
- DATA_W, 32, channel data width
- NUM_IN, 9, number of source channels; index NUM_IN-1 is the register-file input
- NUM_OUT, 3, number of sink channels
- SEL_W, 4, select field width per output; must satisfy 2^SEL_W > NUM_IN
- CFG_DEPTH, 4, number of stored contexts; CW = clog2(CFG_DEPTH), minimum 1

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_data  in  NUM_IN*DATA_W  source data; channel i at [i*DATA_W +: DATA_W]
- in_valid  in  NUM_IN  source valid
- in_ready  out  NUM_IN  source consumed this cycle when in_valid & in_ready
- out_data  out  NUM_OUT*DATA_W  registered sink data
- out_valid  out  NUM_OUT  sink valid
- out_ready  in  NUM_OUT  sink accepts
- cfg_we  in  1  write context entry
- cfg_addr  in  CW  context index to write
- cfg_data  in  NUM_OUT*SEL_W  select word; output o uses field [o*SEL_W +: SEL_W]
- ctx_req  in  1  request switch to ctx_id
- ctx_id  in  CW  requested context
- ctx_cur  out  CW  active context
- ctx_busy  out  1  switch pending

Behaviour:
- Select decode per output field s:
  - s < NUM_IN: source s.
  - NUM_IN <= s < 2^SEL_W-1: source NUM_IN-1 (legacy register-file default).
  - s == all-ones: output disabled. It never loads and never constrains in_ready.
- Reset:
  - Every context entry is written all-ones (all outputs disabled).
  - out_valid=0, out_data=0, ctx_cur=0, ctx_busy=0, pending id=0.
- can_load[o] = !out_valid[o] | out_ready[o].
- in_ready[i] = !ctx_busy & AND over enabled outputs o selecting i of can_load[o].
  - If no enabled output selects i, in_ready[i]=0. Unrouted sources are never consumed.
- Output o loads when enabled & in_valid[src] & in_ready[src]:
  - next cycle out_valid[o]=1 and out_data[o]=in_data[src].
  - Else, if out_ready[o] is high, out_valid[o] clears and out_data holds its last value.
- Fork rule: a source feeding k outputs is consumed exactly once, in the cycle all k can load. All k outputs receive the same word in the same cycle. No partial delivery.
- Latency: 1 cycle from the input handshake to out_valid. Throughput is 1 word/cycle per output when out_ready is held high.
- Select lookup is combinational from the active context. A cfg_we to the active context takes effect the cycle after the write.
- Context switch:
  - ctx_req latches ctx_id as pending and sets ctx_busy.
  - While ctx_busy is set, all in_ready=0, and out handshakes continue.
  - The first cycle with out_valid==0 on all outputs: ctx_cur <= pending, ctx_busy <= 0. The new context routes from the following cycle.
  - If outputs are already empty, the switch completes 1 cycle after ctx_req.
- Simultaneous events:
  - ctx_req while busy overwrites the pending id, and drain continues.
  - ctx_req in the completion cycle wins: busy stays 1 with the new id.
  - cfg_we and ctx_req to the same context in the same cycle: the write lands first, so the new context uses the written word.
- rst mid-operation (including mid-drain) discards in-flight output words and the pending switch.

Test Plan:
- Reset, then pulse in_valid on all inputs -> in_ready=0, out_valid=0 for 10 cycles (all contexts disabled).
- ctx0 = {out2=8, out1=1, out0=0}; ctx_req ctx_id=0; in0=0x11, in1=0x22, in8=0xRF all valid, out_ready=1 -> one cycle later out_data = 0x11/0x22/RF word, valid each cycle.
- ctx0 out0=3, out1=3, out1 out_ready=0 after first load -> in_ready[3] drops, out0 stalls holding 0xAA, no duplicate/loss. Release -> both get next word 0xBB same cycle.
- ctx1 selects {15, 12, 2}: out2 disabled, out1 from in8, out0 from in2 -> out_valid[2] stays 0; out1 data = in8.
- Two words in flight, out_ready=0, ctx_req id=1 -> ctx_busy=1, in_ready=0. Raise out_ready -> ctx_cur=1 the cycle after outputs empty, then ctx1 routing active.
- rst asserted while ctx_busy=1 with out_valid=3'b111 -> next cycle all out_valid=0, ctx_busy=0, ctx_cur=0.
